// File: rtl/mul_div_pkg.sv
// Shared definitions for the multi-cycle multiply/divide engine.
package mul_div_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter width for a given operand width
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/div_step.sv
// One non-restoring division step: shift in the next dividend bit, then
// subtract the divisor from a non-negative partial remainder or add it to a
// negative one. The new quotient bit is 1 when the result is non-negative.
module div_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic signed [WIDTH+1:0] p,
  input  logic        [WIDTH-1:0] q,
  input  logic        [WIDTH-1:0] d,
  output logic signed [WIDTH+1:0] p_next,
  output logic        [WIDTH-1:0] q_next
);

  logic signed [WIDTH+1:0] shifted;
  logic signed [WIDTH+1:0] d_ext;

  // Add/sub-and-shift for a single quotient bit
  always_comb begin
    shifted = {p[WIDTH:0], q[WIDTH-1]};
    d_ext   = {2'b00, d};
    if (p[WIDTH+1]) p_next = shifted + d_ext;
    else            p_next = shifted - d_ext;
    q_next = {q[WIDTH-2:0], ~p_next[WIDTH+1]};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (non-restoring)
// engine. Results are published on z_high/z_low only when done pulses.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low,
  output logic             div_by_zero
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t                  state;
  logic [CW-1:0]           count;
  logic                    dz_pend;
  logic                    op_q;

  // Booth state: upper field is WIDTH+1 bits so MIN*MIN cannot overflow
  logic signed [2*WIDTH:0] acc;
  logic                    qm1;
  logic signed [WIDTH:0]   mcand;
  logic signed [WIDTH:0]   booth_hi;
  logic signed [WIDTH:0]   booth_sum;
  logic signed [2*WIDTH:0] acc_next;

  // Divider state works on magnitudes; signs are applied in FIX
  logic signed [WIDTH+1:0] prem;
  logic signed [WIDTH+1:0] prem_next;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH-1:0]        quo_next;
  logic [WIDTH-1:0]        dvs;
  logic                    q_neg;
  logic                    r_neg;
  logic [WIDTH-1:0]        rem_mag;

  logic [WIDTH-1:0]        res_hi;
  logic [WIDTH-1:0]        res_lo;

  logic                    accept;
  logic                    div0;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                  input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  assign accept = (state == IDLE) && start;
  assign div0   = (op == OP_DIV) && (b == '0);

  // One Booth step: add/subtract the multiplicand, then arithmetic shift right
  always_comb begin
    booth_hi = acc[2*WIDTH:WIDTH];
    case ({acc[0], qm1})
      2'b01:   booth_sum = booth_hi + mcand;
      2'b10:   booth_sum = booth_hi - mcand;
      default: booth_sum = booth_hi;
    endcase
    acc_next = {booth_sum[WIDTH], booth_sum, acc[WIDTH-1:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .p      (prem),
    .q      (quo),
    .d      (dvs),
    .p_next (prem_next),
    .q_next (quo_next)
  );

  // Restore a negative final partial remainder (only the low bits matter)
  assign rem_mag = prem[WIDTH-1:0] + (prem[WIDTH+1] ? dvs : '0);

  // Datapath: latch operands on accept, iterate in RUN, sign-correct in FIX
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op;
      acc    <= {{(WIDTH+1){1'b0}}, b};
      qm1    <= 1'b0;
      mcand  <= {a[WIDTH-1], a};
      prem   <= '0;
      quo    <= mag(a);
      dvs    <= mag(b);
      q_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
      r_neg  <= a[WIDTH-1];
      res_hi <= a;
      res_lo <= '1;
    end else if (state == RUN) begin
      if (op_q == OP_MUL) begin
        acc <= acc_next;
        qm1 <= acc[0];
      end else begin
        prem <= prem_next;
        quo  <= quo_next;
      end
    end else if (state == FIX) begin
      res_hi <= apply_sign(rem_mag, r_neg);
      res_lo <= apply_sign(quo, q_neg);
    end
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dz_pend     <= 1'b0;
      div_by_zero <= 1'b0;
      z_high      <= '0;
      z_low       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            count       <= '0;
            dz_pend     <= div0;
            state       <= div0 ? DONE : RUN;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == LAST) state <= (op_q == OP_DIV) ? FIX : DONE;
        end
        FIX: begin
          state <= DONE;
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dz_pend;
          if (op_q == OP_MUL) begin
            z_high <= acc[2*WIDTH-1:WIDTH];
            z_low  <= acc[WIDTH-1:0];
          end else begin
            z_high <= res_hi;
            z_low  <= res_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus hand-written
// sequences for ignored starts and mid-operation clear.
module tb_mul_div_unit;

  logic        clk;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] z_high;
  logic [31:0] z_low;
  logic        div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .z_high      (z_high),
    .z_low       (z_low),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation and follow it to done (bounded at 60 edges).
  task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        output int lat, output logic ok_busy, output logic ok_hold,
                        output logic dz_start);
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    prev_hi = z_high; prev_lo = z_low;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~op_i; a = $urandom; b = $urandom;
    dz_start = div_by_zero;
    ok_busy  = busy && !done;
    ok_hold  = 1'b1;
    lat      = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        if (busy) ok_busy = 1'b0;
        break;
      end
      if (!busy) ok_busy = 1'b0;
      if (z_high !== prev_hi || z_low !== prev_lo) ok_hold = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic        ok_busy;
    logic        ok_hold;
    logic        dz_start;
    logic        seen_done;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;

    vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[3]  = '{1'b0, 32'h7FFFFFFF,  32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 33};
    vecs[4]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[5]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[6]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[7]  = '{1'b1, 32'd100,       32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 34};
    vecs[9]  = '{1'b1, 32'h12345678,  32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 1};
    vecs[10] = '{1'b0, 32'd2,         32'd3,        32'h00000000, 32'h00000006, 1'b0, 33};
    vecs[11] = '{1'b1, 32'd5,         32'd7,        32'h00000005, 32'h00000000, 1'b0, 34};

    clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz",   {63'd0, div_by_zero}, 64'd0);
    check("rst_z",    {z_high, z_low}, 64'd0);
    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, ok_busy, ok_hold, dz_start);
      check($sformatf("v%0d_lat", i),  64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_zhi", i),  {32'd0, z_high}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_zlo", i),  {32'd0, z_low},  {32'd0, vecs[i].lo});
      check($sformatf("v%0d_dz", i),   {63'd0, div_by_zero}, {63'd0, vecs[i].dz});
      check($sformatf("v%0d_busy", i), {63'd0, ok_busy}, 64'd1);
      check($sformatf("v%0d_hold", i), {63'd0, ok_hold}, 64'd1);
      check($sformatf("v%0d_dzclr", i), {63'd0, dz_start}, 64'd0);
    end

    // MUL 5*5 with start pulses while running (edge 10) and in DONE (edge 33)
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 10 || n == 33) begin
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_zlo", {32'd0, z_low},  64'h19);
    check("ign_zhi", {32'd0, z_high}, 64'd0);
    check("ign_dz",  {63'd0, div_by_zero}, 64'd0);
    @(posedge clk);
    #1;
    check("ign_idle_busy", {63'd0, busy}, 64'd0);
    check("ign_idle_done", {63'd0, done}, 64'd0);

    // MUL 9*9 aborted by clr at edge 5
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    pre_hi = z_high; pre_lo = z_low;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_dz",   {63'd0, div_by_zero}, 64'd0);
    check("abort_z",    {pre_hi, pre_lo}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_quiet", {63'd0, seen_done}, 64'd0);

    run_op(1'b0, 32'd2, 32'd3, lat, ok_busy, ok_hold, dz_start);
    check("after_lat",  64'(lat), 64'd33);
    check("after_zlo",  {32'd0, z_low},  64'd6);
    check("after_zhi",  {32'd0, z_high}, 64'd0);
    check("after_busy", {63'd0, ok_busy}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
